// File: rtl/md_pkg.sv
// md_pkg: op encoding, FSM states, default latencies and op classification for md_unit.
package md_pkg;
  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO,
    MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN_MUL, S_RUN_DIV} md_state_e;
  localparam int MD_WIDTH = 32;
  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
  function automatic logic is_mul_class(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction
  function automatic logic is_div_class(input logic [3:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational HI/LO result for multiply, multiply-accumulate/subtract and divide.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res
);
  logic sgn, neg_a, neg_b;
  logic [2*WIDTH-1:0] ax, bx, prod, hl;
  logic [WIDTH-1:0] ma, mb, q, r, qs, rs;
  always_comb begin
    sgn = op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    ax = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    // low 2W bits of the extended product are the two's-complement product
    prod = ax * bx;
    hl = {hi, lo};
    // signed divide via magnitudes; min/-1 falls out as q=min, r=0
    ma = neg_a ? -a : a;
    mb = neg_b ? -b : b;
    q = (mb == '0) ? '0 : ma / mb;
    r = (mb == '0) ? '0 : ma % mb;
    qs = (neg_a ^ neg_b) ? -q : q;
    rs = neg_a ? -r : r;
    res = (op inside {MD_MULT, MD_MULTU}) ? prod :
          (op inside {MD_MADD, MD_MADDU}) ? hl + prod :
          (op inside {MD_MSUB, MD_MSUBU}) ? hl - prod :
          is_div_class(op) ? ((b == '0) ? {a, {WIDTH{1'b1}}} : {rs, qs}) : hl;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO register pair with fixed-latency multiply/divide, cancellable by pipeline flush.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = MD_WIDTH,
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  md_state_e state;
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] res;
  logic take, go_mul, go_div, done;
  assign take   = state == S_IDLE && start && !cancel;
  assign go_mul = take && is_mul_class(op);
  assign go_div = take && is_div_class(op);
  assign done   = state != S_IDLE && !cancel && cnt == CW'(1);
  assign busy   = state != S_IDLE;
  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op(op_q), .a(a_q), .b(b_q), .hi(hi_q), .lo(lo_q), .res(res)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      hi <= '0;
      lo <= '0;
    end else if (state == S_IDLE) begin
      state <= go_mul ? S_RUN_MUL : go_div ? S_RUN_DIV : S_IDLE;
      cnt <= go_mul ? CW'(MUL_CYCLES) : go_div ? CW'(DIV_CYCLES) : '0;
      if (go_mul || go_div) begin
        op_q <= op;
        a_q <= a;
        b_q <= b;
        hi_q <= hi;
        lo_q <= lo;
      end
      if (take && op == MD_MTHI) hi <= a;
      if (take && op == MD_MTLO) lo <= a;
    end else begin
      state <= (cancel || cnt == CW'(1)) ? S_IDLE : state;
      cnt <= cancel ? '0 : cnt - CW'(1);
      if (done) {hi, lo} <= res;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against a longint reference model.
module tb_md_unit;
  localparam int MULN = 5;
  localparam int DIVN = 10;
  logic clk = 0, reset = 0, start = 0, cancel = 0, busy;
  logic [3:0] op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic [31:0] mhi = 0, mlo = 0;
  int checks = 0, errors = 0;

  md_unit #(.WIDTH(32), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, y, h, l);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    acc = {h, l};
    case (o)
      4'd1: return 64'(sx * sy);
      4'd2: return 64'(ux * uy);
      4'd3, 4'd4: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy; r = sx % sy; uq = ux / uy; ur = ux % uy;
        return (o == 4'd3) ? {r[31:0], q[31:0]} : {ur[31:0], uq[31:0]};
      end
      4'd5: return {x, l};
      4'd6: return {h, x};
      4'd7: return acc + 64'(sx * sy);
      4'd8: return acc + 64'(ux * uy);
      4'd9: return acc - 64'(sx * sy);
      4'd10: return acc - 64'(ux * uy);
      default: return acc;
    endcase
  endfunction

  // c: 0 = no cancel, <0 = cancel alongside start, k>0 = cancel during busy cycle k
  task automatic run(input logic [3:0] o, input logic [31:0] x, y, input int c);
    int n;
    logic [63:0] exp;
    exp = model(o, x, y, mhi, mlo);
    n = (o inside {1, 2, 7, 8, 9, 10}) ? MULN : (o inside {3, 4}) ? DIVN : 0;
    start = 1; op = o; a = x; b = y; cancel = (c < 0);
    step();
    start = 0; cancel = 0;
    if (c < 0) begin
      exp = {mhi, mlo};
      n = 0;
    end
    for (int i = 1; i <= n; i++) begin
      chk("busy_in_flight", {31'd0, busy}, 32'd1);
      cancel = (i == c);
      start = 1'($urandom_range(0, 1));
      op = 4'($urandom);
      a = $urandom;
      b = $urandom;
      step();
      if (i == c) begin
        exp = {mhi, mlo};
        break;
      end
    end
    start = 0; cancel = 0;
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi", hi, exp[63:32]);
    chk("lo", lo, exp[31:0]);
    {mhi, mlo} = exp;
  endtask

  initial begin
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    step();
    reset = 1;
    step();
    run(4'd1, 32'hFFFFFFFD, 32'd7, 0);
    chk("mult_hi_k", hi, 32'hFFFFFFFF);
    chk("mult_lo_k", lo, 32'hFFFFFFEB);
    run(4'd2, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu_hi_k", hi, 32'h00000001);
    chk("multu_lo_k", lo, 32'hFFFFFFFE);
    run(4'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_lo_k", lo, 32'hFFFFFFFD);
    chk("div_hi_k", hi, 32'hFFFFFFFF);
    run(4'd4, 32'd7, 32'd0, 0);
    chk("divu0_lo_k", lo, 32'hFFFFFFFF);
    chk("divu0_hi_k", hi, 32'h00000007);
    run(4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf_lo_k", lo, 32'h80000000);
    chk("ovf_hi_k", hi, 32'd0);
    run(4'd6, 32'hFFFFFFFF, 32'd0, 0);
    run(4'd5, 32'd0, 32'd0, 0);
    run(4'd7, 32'd1, 32'd1, 0);
    chk("madd_hi_k", hi, 32'h00000001);
    chk("madd_lo_k", lo, 32'h00000000);
    run(4'd5, 32'd0, 32'd0, 0);
    run(4'd6, 32'd0, 32'd0, 0);
    run(4'd10, 32'd1, 32'd1, 0);
    chk("msubu_hi_k", hi, 32'hFFFFFFFF);
    chk("msubu_lo_k", lo, 32'hFFFFFFFF);
    run(4'd5, 32'h1234, 32'd0, 0);
    run(4'd3, 32'd9, 32'd2, 3);
    chk("cancel_hi_k", hi, 32'h1234);
    run(4'd1, 32'd3, 32'd3, 0);
    chk("after_cancel_lo_k", lo, 32'd9);
    run(4'd1, 32'd5, 32'd5, MULN);
    run(4'd4, 32'd100, 32'd7, DIVN);
    run(4'd6, 32'hDEADBEEF, 32'd0, -1);
    run(4'd5, 32'hCAFEF00D, 32'd0, -1);
    run(4'd12, 32'h11111111, 32'd0, 0);
    // asynchronous reset in the middle of a multiply
    start = 1; op = 4'd1; a = 32'd5; b = 32'd6;
    step();
    start = 0;
    step();
    #2 reset = 0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    mhi = 0; mlo = 0;
    step();
    chk("arst_hold_lo", lo, 32'd0);
    reset = 1;
    step();
    run(4'd8, 32'd7, 32'd8, 0);
    chk("post_rst_lo_k", lo, 32'd56);
    for (int t = 0; t < 80; t++) begin
      int c;
      logic [3:0] o;
      logic [31:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if ($urandom_range(0, 15) == 0) x = 32'h80000000;
      if ($urandom_range(0, 15) == 0) y = 32'hFFFFFFFF;
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DIVN + 1) - 1 : 0;
      run(o, x, y, c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit for the execute stage of the pipelined CPU. It holds the HI/LO register pair and runs signed and unsigned multiply, divide, multiply-accumulate and multiply-subtract. Each operation has a configurable fixed latency, and the unit raises `busy` while an operation is in flight. A `cancel` input aborts in-flight work on an exception or interrupt flush, leaving HI/LO architecturally unchanged.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `MUL_CYCLES`, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (≥1).
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  op valid this cycle.
- `op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 ignored.
- `a`  in  WIDTH  rs operand (forwarded value).
- `b`  in  WIDTH  rt operand (forwarded value).
- `cancel`  in  1  flush; aborts the current or incoming operation.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN_MUL, RUN_DIV.
- IDLE, `start` with a mul-class op, `cancel`=0:
  - capture `a`, `b`, `op`, and the current HI/LO;
  - load the counter with MUL_CYCLES;
  - go to RUN_MUL.
- IDLE, `start` with div/divu, `cancel`=0: same capture, counter = DIV_CYCLES, go to RUN_DIV.
- IDLE, `start` with mthi/mtlo, `cancel`=0: write `a` into HI or LO at that edge; no busy.
- RUN_*: counter decrements each edge. On the edge where the counter reaches 0:
  - the result is written to HI/LO;
  - `busy` deasserts;
  - the FSM returns to IDLE.
- `start` while busy is ignored (including mthi/mtlo). Upstream stall logic holds the instruction in E while `busy`.
- `cancel`=1:
  - in RUN_*: return to IDLE at the next edge, HI/LO untouched, result discarded;
  - together with `start` in IDLE: start dropped, including mthi/mtlo.
- Arithmetic, 2·WIDTH product P:
  - mult/multu: {HI,LO}=P;
  - madd(u): {HI,LO}=captured {HI,LO}+P;
  - msub(u): {HI,LO}=captured {HI,LO}−P;
  - all modulo 2^(2·WIDTH); signed forms use two's-complement P.
- div/divu: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
- Divide by zero: LO=all ones, HI=`a`.
- Signed overflow (min / −1): LO=min, HI=0.

## Timing
- Reset (asynchronous, `reset`=0): FSM=IDLE, counter=0, `busy`=0, `hi`=0, `lo`=0, immediately and regardless of the clock. Reset asserted mid-operation aborts the operation.
- Start sampled at edge k: `busy`=1 from after edge k until edge k+N (N = MUL_CYCLES or DIV_CYCLES). HI/LO take the new value at edge k+N, and `busy`=0 in the same cycle.
- mthi/mtlo: HI/LO visible one cycle after the start edge.
- Back-to-back: a start presented in the first cycle after `busy` falls is accepted.
- `hi`/`lo` are driven directly from registers; no combinational path from the inputs.
- A `cancel` that arrives on the completion edge wins: no write.

## Structure
- Package `md_pkg` holds:
  - the op encoding as an enum (`MD_NONE` … `MD_MSUBU`);
  - the state enum;
  - the default latency constants;
  - helper function `is_mul_class(op)`.
- Sub-module `md_arith` is combinational. It takes the captured operands, op and HI/LO and produces the 2·WIDTH result, including the divide-by-zero and overflow rules.
- `md_unit` owns the FSM, counter, capture registers and HI/LO.

## Test plan
- mult a=0xFFFFFFFD, b=7 → `busy` high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7), b=2 → `busy` 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007.
- mtlo 0xFFFFFFFF, then mthi 0; madd a=1, b=1 → hi=0x00000001, lo=0x00000000.
- msubu from hi=0, lo=0 with a=1, b=1 → hi=lo=0xFFFFFFFF.
- mthi 0x1234, then div 9/2 with `cancel` pulsed in busy cycle 3 → `busy` low next cycle, hi=0x1234, lo unchanged. An immediate mult 3×3 is then accepted → lo=9 after 5 cycles.
- `reset` pulled low during RUN_MUL between edges → `busy`, `hi` and `lo` read 0 before the next edge. After release, a start while the previous op was mid-flight gives a clean fresh result.
